alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
Parametrised next-generation ALU control unit. Decodes ALUOp plus the full 6-bit funct field into a 4-bit ALU control code, and executes the accepted operation. Single-cycle ops complete in one cycle. Shift and multiply ops run iteratively, which lets a multi-cycle datapath stall on busy instead of carrying a barrel shifter and array multiplier. Sits between main control and the register-file write-back path.

Parameters:
WIDTH, 32, operand/result width in bits
CTRL_W, 4, ALU control code width
SH_W, 5, shift-amount width; must equal clog2(WIDTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  issue request; accepted only when ready=1
aluop  in  2  main-control ALUOp
funct  in  6  instruction funct field
shamt  in  SH_W  shift amount
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt/immediate)
ready  out  1  unit idle, can accept start
busy  out  1  multi-cycle op in progress (= not ready)
gout  out  CTRL_W  registered control code of last accepted op
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  registered result, held until next done
zero  out  1  result == 0, registered with result
err  out  1  set with done when op was illegal

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, ready=1, busy=0, done=0, err=0, result=0, zero=1, gout=4'b0010.
- Decode, applied at acceptance:
  - aluop=00 -> ADD 0010.
  - aluop=01 -> SUB 0110.
  - aluop=11 -> OR 0001.
  - aluop=10, by funct:
    - 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001; 101010 SLT 0111.
    - 000000 SLL 0011; 000010 SRL 0100; 011000 MUL 1000.
    - any other funct -> ILLEGAL 1111.
- Acceptance: start && ready at edge N. Latch gout, a, b, shamt.
- States:
  - IDLE -> EXEC for single-cycle ops and ILLEGAL.
  - IDLE -> SHIFT for SLL/SRL.
  - IDLE -> MUL for MUL.
  - Every state returns to IDLE on the edge that asserts done.
- Single-cycle ops: done at edge N+1.
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is signed two's-complement compare; result 1 or 0.
- ILLEGAL: done and err at N+1, result=0, zero=1.
- SHIFT: shifts b one bit per cycle, zero fill; done at N+max(shamt,1).
  - shamt=0 gives done at N+1 with result=b.
- MUL: shift-add, one multiplier bit per cycle, unsigned. Result is the low WIDTH bits. done at N+WIDTH.
- start while busy: ignored; latched operands and gout are unchanged.
- done is high exactly one cycle. err clears on the next done.
- zero is computed from the value being written into result.
- ready rises in the cycle done is high, so back-to-back issue is possible: start sampled with done=1 is accepted.
- Reset mid-operation: abort, no done pulse, all outputs return to reset values next edge.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_MUL, ALU_ILL).
  - funct constants.
  - State encoding (IDLE, EXEC, SHIFT, MUL).
- One natural sub-module: alu_ctrl_dec, a purely combinational aluop/funct -> gout decoder. It is reusable by the single-cycle datapath.
- Sequencer, iteration counter and datapath stay in alu_ctrl_seq.

Test Plan:
1. Reset, then aluop=10 funct=100000 a=7 b=5 -> done at N+1, result=12, gout=0010, zero=0. Then SUB with a=b=5 -> result=0, zero=1.
2. aluop=10 funct=101010 a=32'hFFFFFFFF b=1 -> result=1, gout=0111. Swap operands -> result=0.
3. SLL shamt=4 b=32'h0000000F -> busy for cycles N+1..N+3, done at N+4, result=32'h000000F0. SRL shamt=0 b=32'h80000000 -> done at N+1, result=32'h80000000.
4. MUL a=32'h00010001 b=32'h00010001 -> done at N+32, result=32'h00020001. Extra start pulses during busy are ignored.
5. aluop=10 funct=111111 -> done and err at N+1, gout=1111, result=0. Next legal op clears err.
6. Start MUL, assert reset at N+10 -> next edge ready=1, done=0, result=0, gout=0010, no done pulse. Then back-to-back: start held high across a done -> second op is accepted on the done edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control unit: control codes, ALUOp/funct encodings
// and the sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_ILL = 4'b1111;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_OR    = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        SHIFT = 2'b10,
        MUL   = 2'b11
    } state_t;

    // Illegal codes go through EXEC so they finish in one cycle like any simple op.
    function automatic state_t issue_state(input logic [3:0] code);
        case (code)
            ALU_SLL, ALU_SRL: return SHIFT;
            ALU_MUL:          return MUL;
            default:          return EXEC;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Issue/result bundle between the issuing control path (master) and the ALU unit (slave).
interface alu_ctrl_seq_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int SH_W   = 5
);
    logic              start;
    logic [1:0]        aluop;
    logic [5:0]        funct;
    logic [SH_W-1:0]   shamt;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              ready;
    logic              busy;
    logic [CTRL_W-1:0] gout;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              err;

    modport master (
        output start, aluop, funct, shamt, a, b,
        input  ready, busy, gout, done, result, zero, err
    );

    modport slave (
        input  start, aluop, funct, shamt, a, b,
        output ready, busy, gout, done, result, zero, err
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct to ALU control code decoder; shared with the single-cycle datapath.
import alu_pkg::*;

module alu_ctrl_dec #(
    parameter int CTRL_W = 4
) (
    input  logic [1:0]        i_aluop,
    input  logic [5:0]        i_funct,
    output logic [CTRL_W-1:0] o_gout
);
    logic [3:0] w_code;

    // Decode; funct only matters for R-type, anything unrecognised is illegal.
    always_comb begin
        w_code = ALU_ILL;
        case (i_aluop)
            OP_ADD:   w_code = ALU_ADD;
            OP_SUB:   w_code = ALU_SUB;
            OP_OR:    w_code = ALU_OR;
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  w_code = ALU_ADD;
                    FN_SUB:  w_code = ALU_SUB;
                    FN_AND:  w_code = ALU_AND;
                    FN_OR:   w_code = ALU_OR;
                    FN_SLT:  w_code = ALU_SLT;
                    FN_SLL:  w_code = ALU_SLL;
                    FN_SRL:  w_code = ALU_SRL;
                    FN_MUL:  w_code = ALU_MUL;
                    default: w_code = ALU_ILL;
                endcase
            end
            default:  w_code = ALU_ILL;
        endcase
    end

    assign o_gout = CTRL_W'(w_code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Iterative ALU control/execute unit: single-cycle ops finish in one cycle, shifts and
// multiplies run one bit per cycle while busy stalls the issuer.
import alu_pkg::*;

module alu_ctrl_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int SH_W   = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_ctrl_seq_if.slave bus
);
    localparam logic [SH_W-1:0]   CNT_ZERO = {SH_W{1'b0}};
    localparam logic [SH_W-1:0]   CNT_ONE  = {{(SH_W-1){1'b0}}, 1'b1};
    localparam logic [SH_W-1:0]   MUL_LAST = SH_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CTRL_W-1:0] GOUT_RST = CTRL_W'(ALU_ADD);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CTRL_W-1:0] w_dec_code;
    logic [CTRL_W-1:0] r_gout;
    logic [WIDTH-1:0]  r_opa;
    logic [WIDTH-1:0]  r_opb;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_result;
    logic [SH_W-1:0]   r_cnt;
    logic              r_done;
    logic              r_zero;
    logic              r_err;
    logic              w_ready;
    logic              w_accept;
    logic              w_finish;
    logic [WIDTH-1:0]  w_shift1;
    logic [WIDTH-1:0]  w_acc_nxt;
    logic [WIDTH-1:0]  w_res_val;

    alu_ctrl_dec #(.CTRL_W(CTRL_W)) u_dec (
        .i_aluop (bus.aluop),
        .i_funct (bus.funct),
        .o_gout  (w_dec_code)
    );

    assign w_accept = bus.start && w_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; every working state falls back to IDLE on its finishing edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = issue_state(w_dec_code);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: w_state_nxt = IDLE;
            SHIFT: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            MUL: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = MUL;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output/datapath decode: handshake flags, one shift/add step and the finishing value.
    always_comb begin
        w_ready   = (r_state == IDLE);
        w_finish  = 1'b0;
        w_res_val = ZERO_W;
        if (r_gout == CTRL_W'(ALU_SRL)) begin
            w_shift1 = {1'b0, r_opb[WIDTH-1:1]};
        end else begin
            w_shift1 = {r_opb[WIDTH-2:0], 1'b0};
        end
        if (r_opb[0]) begin
            w_acc_nxt = r_acc + r_opa;
        end else begin
            w_acc_nxt = r_acc;
        end
        case (r_state)
            EXEC: begin
                w_finish = 1'b1;
                case (r_gout)
                    CTRL_W'(ALU_ADD): w_res_val = r_opa + r_opb;
                    CTRL_W'(ALU_SUB): w_res_val = r_opa - r_opb;
                    CTRL_W'(ALU_AND): w_res_val = r_opa & r_opb;
                    CTRL_W'(ALU_OR):  w_res_val = r_opa | r_opb;
                    CTRL_W'(ALU_SLT): w_res_val = ($signed(r_opa) < $signed(r_opb)) ? ONE_W : ZERO_W;
                    default:          w_res_val = ZERO_W;
                endcase
            end
            SHIFT: begin
                w_finish = (r_cnt <= CNT_ONE);
                // A zero shift amount still takes one cycle and returns b untouched.
                if (r_cnt == CNT_ZERO) begin
                    w_res_val = r_opb;
                end else begin
                    w_res_val = w_shift1;
                end
            end
            MUL: begin
                w_finish  = (r_cnt == CNT_ZERO);
                w_res_val = w_acc_nxt;
            end
            default: begin
                w_finish  = 1'b0;
                w_res_val = ZERO_W;
            end
        endcase
    end

    // Operand latching, iteration stepping and registered result/flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gout   <= GOUT_RST;
            r_opa    <= ZERO_W;
            r_opb    <= ZERO_W;
            r_acc    <= ZERO_W;
            r_cnt    <= CNT_ZERO;
            r_result <= ZERO_W;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_gout <= w_dec_code;
                r_opa  <= bus.a;
                r_opb  <= bus.b;
                r_acc  <= ZERO_W;
                if (w_dec_code == CTRL_W'(ALU_MUL)) begin
                    r_cnt <= MUL_LAST;
                end else begin
                    r_cnt <= bus.shamt;
                end
            end else if (r_state == SHIFT && !w_finish) begin
                r_opb <= w_shift1;
                r_cnt <= r_cnt - CNT_ONE;
            end else if (r_state == MUL && !w_finish) begin
                r_acc <= w_acc_nxt;
                r_opa <= {r_opa[WIDTH-2:0], 1'b0};
                r_opb <= {1'b0, r_opb[WIDTH-1:1]};
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_finish) begin
                r_result <= w_res_val;
                r_zero   <= (w_res_val == ZERO_W);
                r_err    <= (r_state == EXEC) && (r_gout == CTRL_W'(ALU_ILL));
            end
        end
    end

    assign bus.ready  = w_ready;
    assign bus.busy   = !w_ready;
    assign bus.gout   = r_gout;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.err    = r_err;

endmodule
